pe_row_mac: RTL and testbench
=============================

Name: pe_row_mac

Overview:
- Parametrised row-stationary PE, successor to the fixed 3-tap 8x4 PE.
- Holds TAPS stationary weights and a TAPS-deep sliding ifmap window. Multiplies tap-wise, sums the products with the upstream partial sum, and emits a saturated psum with a valid strobe.
- Sits in a systolic row: ifmap and filter are forwarded to the neighbour PE, and psum chains PE to PE.
- Adds valid handshaking, a window-fill tracker, row restart, a 2-stage pipeline, a global stall and saturation, none of which the previous PE had.

Parameters:
- DATA_W, 8, ifmap sample width (unsigned).
- WGT_W, 4, weight width per tap (unsigned).
- TAPS, 3, window depth and multiplier count; must be >= 2.
- PSUM_W, 16, psum width; must be >= DATA_W+WGT_W+clog2(TAPS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  global clock-enable; low freezes all state.
- filt_load  in  1  load weight register.
- filt_in  in  TAPS*WGT_W  weights; lane k = filt_in[k*WGT_W +: WGT_W].
- filt_out  out  TAPS*WGT_W  weight register, forwarded to the neighbour PE.
- ifmap_valid  in  1  ifmap_in/psum_in carry a sample this cycle.
- row_start  in  1  qualifies ifmap_valid; the sample begins a new row.
- ifmap_in  in  DATA_W  incoming sample.
- ifmap_out  out  DATA_W  newest stored sample (tap0 register), forwarded.
- psum_in  in  PSUM_W  upstream partial sum, aligned to ifmap_valid.
- psum_valid_out  out  1  psum_out valid.
- psum_out  out  PSUM_W  result.
- sat_flag  out  1  result was clamped; meaningful only with psum_valid_out.

Behaviour:
- Reset (rst_n low at edge, overrides en): all registers to 0, so all outputs are 0 and the fill count is 0.
- Accept: a sample is accepted at an edge where en=1 and ifmap_valid=1.
- Window: win[0] = ifmap_in and win[k] = sr[k-1], where sr is the TAPS-1 newest previously accepted samples. sr shifts on accept. ifmap_out = sr[0].
- Fill: fill counts accepted samples, saturating at TAPS-1.
  - A window is complete when fill == TAPS-1 at the accept.
  - row_start=1 on an accept discards history: treat fill as 0 and sr as don't-care. The window is therefore never complete on that sample, and fill becomes 1.
  - row_start without ifmap_valid is ignored.
- Stage 1 (accept edge E0):
  - Register p[k] = win[k]*W[k] at full width DATA_W+WGT_W.
  - Register psum_in.
  - Register v1 = window complete.
  - If not an accept, v1 <= 0 and the data registers hold.
- Stage 2 (next edge with en=1):
  - s = psum_reg + sum(p[k]), computed at PSUM_W+1 bits.
  - If s > 2^PSUM_W-1: psum_out = all ones and sat_flag = 1. Otherwise psum_out = s and sat_flag = 0.
  - psum_valid_out <= v1.
- Latency: a result is visible 2 enabled cycles after its input cycle. Throughput is 1 per cycle.
- Weights:
  - W loads from filt_in at an edge with en && filt_load.
  - An accept in the same cycle uses the old W.
  - filt_out = W.
- Stall: en=0 holds every register, including psum_valid_out. The downstream PE must sample under the same en.
- Data outputs: psum_out and sat_flag hold their last values when psum_valid_out=0.

Decomposition:
- Package pe_pkg:
  - default DATA_W/WGT_W/TAPS/PSUM_W constants;
  - a clog2 function;
  - a localparam-style function for product width and sum width.
- Sub-module pe_tap_shift: sr register, fill counter, window output and window-complete flag, with parameters DATA_W and TAPS.
- Multiply/adder/saturation logic stays in pe_row_mac.

Test Plan:
1. Defaults, filt_in=12'h321 loaded (W=1,2,3). Stream 10,20,30,40 with psum_in=0 and row_start on 10 -> valid results 100 then 160, each 2 cycles after its input; no valid output for the first 2 samples.
2. Same weights, psum_in=1000 on the sample 30 -> psum_out=1100, sat_flag=0.
3. Saturation: W=15,15,15, samples 255x3, psum_in=60000 on the third -> sum 71475 gives psum_out=65535, sat_flag=1. psum_in=50000 -> 61475, sat_flag=0.
4. row_start on the 4th sample of a running stream -> no valid output for it or the next sample; the first new valid window uses only post-restart samples.
5. Drop en for 3 cycles mid-stream -> all outputs frozen, including psum_valid_out. On resume the results match the unstalled sequence exactly.
6. filt_load with new weights in the same cycle as an accept -> that result uses old W and the next uses new W. Drive rst_n low mid-stream -> next cycle all outputs 0 and fill restarts.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and width helpers for the row-stationary PE.
//   DEF_*       default parameter values used by the PE, its tap shifter and its interface
//   clog2       ceiling log2, usable in parameter expressions
//   prodWidth   width of one tap product (sample times weight, no truncation)
//   sumWidth    width that holds the sum of all tap products without overflow
package pe_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_WGT_W  = 4;
  localparam int DEF_TAPS   = 3;
  localparam int DEF_PSUM_W = 16;

  // Ceiling log2; clog2(1) = 0, clog2(3) = 2, clog2(4) = 2.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int prodWidth(input int dataW, input int wgtW);
    return dataW + wgtW;
  endfunction

  function automatic int sumWidth(input int dataW, input int wgtW, input int taps);
    return dataW + wgtW + clog2(taps);
  endfunction

endpackage

// File: rtl/pe_row_mac_if.sv
// pe_row_mac_if: the PE's data and handshake bundle.
//   filt_load/filt_in      weight load strobe and packed per-tap weights (into the PE)
//   filt_out               stored weights, forwarded to the neighbour PE
//   ifmap_valid/row_start  sample strobe and start-of-row qualifier (into the PE)
//   ifmap_in/ifmap_out     incoming sample / newest stored sample forwarded on
//   psum_in                upstream partial sum, aligned with ifmap_valid
//   psum_valid_out/psum_out/sat_flag  result strobe, saturated result, clamp flag
// The master modport is the side feeding the PE; slave is the PE itself.
interface pe_row_mac_if
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WGT_W  = DEF_WGT_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int PSUM_W = DEF_PSUM_W
);

  logic                    filt_load;
  logic [TAPS*WGT_W-1:0]   filt_in;
  logic [TAPS*WGT_W-1:0]   filt_out;
  logic                    ifmap_valid;
  logic                    row_start;
  logic [DATA_W-1:0]       ifmap_in;
  logic [DATA_W-1:0]       ifmap_out;
  logic [PSUM_W-1:0]       psum_in;
  logic                    psum_valid_out;
  logic [PSUM_W-1:0]       psum_out;
  logic                    sat_flag;

  modport master (
    output filt_load, filt_in, ifmap_valid, row_start, ifmap_in, psum_in,
    input  filt_out, ifmap_out, psum_valid_out, psum_out, sat_flag
  );

  modport slave (
    input  filt_load, filt_in, ifmap_valid, row_start, ifmap_in, psum_in,
    output filt_out, ifmap_out, psum_valid_out, psum_out, sat_flag
  );

endinterface

// File: rtl/pe_tap_shift.sv
// pe_tap_shift: sliding ifmap window and window-fill tracker.
//   clk, rst_n       clock, synchronous active-low reset
//   en_i             global enable; low freezes the shifter and fill count
//   sampleValid_i    a sample is presented this cycle
//   rowStart_i       the presented sample begins a new row
//   sample_i         the presented sample
//   win_o            window: lane 0 is the live sample, lane k the k-th older stored sample
//   winComplete_o    the window formed with the live sample is fully populated
//   newest_o         most recently stored sample
module pe_tap_shift
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        sampleValid_i,
  input  logic                        rowStart_i,
  input  logic [DATA_W-1:0]           sample_i,
  output logic [TAPS-1:0][DATA_W-1:0] win_o,
  output logic                        winComplete_o,
  output logic [DATA_W-1:0]           newest_o
);

  localparam int FILL_W = clog2(TAPS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS - 1);

  logic [TAPS-2:0][DATA_W-1:0] sr_q, sr_d;
  logic [FILL_W-1:0]           fill_q, fill_d;
  logic                        accept;

  assign accept   = en_i & sampleValid_i;
  assign newest_o = sr_q[0];

  // The window feeds the multipliers combinationally, so lane 0 is the
  // live input rather than a stored sample.
  always_comb begin
    win_o    = '0;
    win_o[0] = sample_i;
    for (int k = 1; k < TAPS; k++) begin
      win_o[k] = sr_q[k-1];
    end
  end

  // A row restart discards history, so the restarting sample can never
  // close a window regardless of what the fill count says.
  assign winComplete_o = !rowStart_i && (fill_q == FILL_MAX);

  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (accept) begin
      sr_d[0] = sample_i;
      for (int k = 1; k < TAPS - 1; k++) begin
        sr_d[k] = sr_q[k-1];
      end
      if (rowStart_i) begin
        fill_d = FILL_W'(1);
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pe_row_mac.sv
// pe_row_mac: parametrised row-stationary processing element.
//   clk, rst_n  clock, synchronous active-low reset (overrides en)
//   en          global enable; low holds every register
//   bus         pe_row_mac_if slave: weight load/forward, ifmap stream in/forward,
//               upstream psum in, saturated psum out with valid strobe and clamp flag
// Two stages: tap products are registered at the accept edge, then summed
// with the upstream psum and saturated at the following enabled edge.
module pe_row_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WGT_W  = DEF_WGT_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int PSUM_W = DEF_PSUM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  pe_row_mac_if.slave   bus
);

  localparam int PROD_W = prodWidth(DATA_W, WGT_W);
  localparam int SUM_W  = PSUM_W + 1;

  logic [TAPS*WGT_W-1:0]       wgt_q;
  logic [TAPS-1:0][DATA_W-1:0] win;
  logic                        winComplete;
  logic [DATA_W-1:0]           newest;
  logic                        accept;

  logic [TAPS-1:0][PROD_W-1:0] prod_q, prod_d;
  logic [PSUM_W-1:0]           psumIn_q;
  logic                        v1_q;

  logic [SUM_W-1:0]            sum_d;
  logic [PSUM_W-1:0]           psumSat_d;
  logic [PSUM_W-1:0]           psumOut_q;
  logic                        sat_q;
  logic                        valid_q;

  assign accept = en & bus.ifmap_valid;

  pe_tap_shift #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_tapShift (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .sampleValid_i (bus.ifmap_valid),
    .rowStart_i    (bus.row_start),
    .sample_i      (bus.ifmap_in),
    .win_o         (win),
    .winComplete_o (winComplete),
    .newest_o      (newest)
  );

  // Products use the weights currently held, so a load in the same cycle
  // as an accept only affects later samples.
  always_comb begin
    prod_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = PROD_W'(win[k]) * PROD_W'(wgt_q[k*WGT_W +: WGT_W]);
    end
  end

  // One extra bit above PSUM_W is enough: the product sum fits in PSUM_W
  // bits and psum_in is below 2^PSUM_W, so the top bit set means overflow.
  always_comb begin
    sum_d = SUM_W'(psumIn_q);
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + SUM_W'(prod_q[k]);
    end
    psumSat_d = sum_d[PSUM_W] ? '1 : sum_d[PSUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wgt_q <= '0;
    end else if (en && bus.filt_load) begin
      wgt_q <= bus.filt_in;
    end
  end

  // Stage 1 data registers only move on an accept; the valid bit is
  // cleared on any other enabled cycle so bubbles propagate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q   <= '0;
      psumIn_q <= '0;
      v1_q     <= 1'b0;
    end else if (en) begin
      if (accept) begin
        prod_q   <= prod_d;
        psumIn_q <= bus.psum_in;
        v1_q     <= winComplete;
      end else begin
        v1_q     <= 1'b0;
      end
    end
  end

  // Result data holds across bubbles so downstream logic sees a stable bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psumOut_q <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else if (en) begin
      valid_q <= v1_q;
      if (v1_q) begin
        psumOut_q <= psumSat_d;
        sat_q     <= sum_d[PSUM_W];
      end
    end
  end

  assign bus.filt_out       = wgt_q;
  assign bus.ifmap_out      = newest;
  assign bus.psum_out       = psumOut_q;
  assign bus.sat_flag       = sat_q;
  assign bus.psum_valid_out = valid_q;

endmodule

// File: tb/tb_pe_row_mac.sv
// tb_pe_row_mac: self-checking bench for pe_row_mac with default parameters.
// A sample-history model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations at key points.
module tb_pe_row_mac;

  localparam int DATA_W = 8;
  localparam int WGT_W  = 4;
  localparam int TAPS   = 3;
  localparam int PSUM_W = 16;
  localparam int PSUM_MAX = 65535;

  logic clk;
  logic rst_n;
  logic en;

  pe_row_mac_if #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .TAPS   (TAPS),
    .PSUM_W (PSUM_W)
  ) bus ();

  pe_row_mac #(
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .TAPS   (TAPS),
    .PSUM_W (PSUM_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passes = 0;

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: samples of the current row (newest first), the weights,
  // one in-flight result, and the outputs the DUT must show.
  int   hist[$];
  logic [TAPS*WGT_W-1:0] mdlWgt;
  bit   pendValid;
  int   pendPsum;
  bit   pendSat;
  bit   expValid;
  int   expPsum;
  bit   expSat;
  int   expIfmap;
  bit   modelLive = 0;

  // Advance the model at each active edge from the stimulus the DUT sees.
  // A result computed at one enabled edge becomes visible at the next one.
  always @(posedge clk) begin
    bit complete;
    int sum;
    if (!rst_n) begin
      hist.delete();
      mdlWgt    = '0;
      pendValid = 0;
      pendPsum  = 0;
      pendSat   = 0;
      expValid  = 0;
      expPsum   = 0;
      expSat    = 0;
      expIfmap  = 0;
      modelLive = 1;
    end else if (en) begin
      expValid = pendValid;
      if (pendValid) begin
        expPsum = pendPsum;
        expSat  = pendSat;
      end
      pendValid = 0;
      if (bus.ifmap_valid) begin
        if (bus.row_start) hist.delete();
        complete = (hist.size() >= TAPS - 1);
        hist.push_front(int'(bus.ifmap_in));
        if (hist.size() > TAPS) void'(hist.pop_back());
        sum = int'(bus.psum_in);
        for (int k = 0; k < TAPS && k < hist.size(); k++) begin
          sum += hist[k] * int'((mdlWgt >> (k * WGT_W)) & 12'hF);
        end
        pendValid = complete;
        pendSat   = (sum > PSUM_MAX);
        pendPsum  = pendSat ? PSUM_MAX : sum;
        expIfmap  = int'(bus.ifmap_in);
      end
      if (bus.filt_load) mdlWgt = bus.filt_in;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cyc_valid", bus.psum_valid_out, expValid);
      checkOutput("cyc_psum",  bus.psum_out, expPsum);
      checkOutput("cyc_sat",   bus.sat_flag, expSat);
      checkOutput("cyc_filt",  bus.filt_out, mdlWgt);
      checkOutput("cyc_ifmap", bus.ifmap_out, expIfmap);
    end
  end

  // Drive one cycle of inputs, then return 2 units after the active edge.
  task automatic applyStimulus(input logic v, input logic rs, input logic [DATA_W-1:0] d,
                               input logic [PSUM_W-1:0] p, input logic fl,
                               input logic [TAPS*WGT_W-1:0] fi);
    bus.ifmap_valid = v;
    bus.row_start   = rs;
    bus.ifmap_in    = d;
    bus.psum_in     = p;
    bus.filt_load   = fl;
    bus.filt_in     = fi;
    @(posedge clk);
    #2;
  endtask

  task automatic sample(input logic rs, input logic [DATA_W-1:0] d, input logic [PSUM_W-1:0] p);
    applyStimulus(1'b1, rs, d, p, 1'b0, '0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic loadW(input logic [TAPS*WGT_W-1:0] w);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, w);
  endtask

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    idle();
    idle();
    checkOutput("rst_valid", bus.psum_valid_out, 0);
    checkOutput("rst_psum",  bus.psum_out, 0);
    checkOutput("rst_sat",   bus.sat_flag, 0);
    checkOutput("rst_filt",  bus.filt_out, 0);
    checkOutput("rst_ifmap", bus.ifmap_out, 0);
    rst_n = 1'b1;

    // Basic stream, W = 1,2,3.
    loadW(12'h321);
    checkOutput("t1_filt", bus.filt_out, 12'h321);
    sample(1'b1, 8'd10, 16'd0);
    sample(1'b0, 8'd20, 16'd0);
    checkOutput("t1_noValid10", bus.psum_valid_out, 0);
    sample(1'b0, 8'd30, 16'd0);
    checkOutput("t1_noValid20", bus.psum_valid_out, 0);
    sample(1'b0, 8'd40, 16'd0);
    checkOutput("t1_valid30", bus.psum_valid_out, 1);
    checkOutput("t1_psum30",  bus.psum_out, 100);
    idle();
    checkOutput("t1_psum40",  bus.psum_out, 160);
    idle();
    checkOutput("t1_bubble",  bus.psum_valid_out, 0);
    checkOutput("t1_hold",    bus.psum_out, 160);

    // Upstream psum added in.
    sample(1'b1, 8'd10, 16'd0);
    sample(1'b0, 8'd20, 16'd0);
    sample(1'b0, 8'd30, 16'd1000);
    idle();
    checkOutput("t2_psum", bus.psum_out, 1100);
    checkOutput("t2_sat",  bus.sat_flag, 0);

    // Saturation boundary.
    loadW(12'hFFF);
    sample(1'b1, 8'd255, 16'd0);
    sample(1'b0, 8'd255, 16'd0);
    sample(1'b0, 8'd255, 16'd60000);
    idle();
    checkOutput("t3_psumSat", bus.psum_out, 65535);
    checkOutput("t3_satFlag", bus.sat_flag, 1);
    sample(1'b0, 8'd255, 16'd50000);
    idle();
    checkOutput("t3_psumNoSat", bus.psum_out, 61475);
    checkOutput("t3_noSatFlag", bus.sat_flag, 0);

    // Row restart mid-stream.
    loadW(12'h321);
    sample(1'b1, 8'd1, 16'd0);
    sample(1'b0, 8'd2, 16'd0);
    sample(1'b0, 8'd3, 16'd0);
    sample(1'b1, 8'd4, 16'd0);
    checkOutput("t4_psum3", bus.psum_out, 10);
    sample(1'b0, 8'd5, 16'd0);
    checkOutput("t4_noValid4", bus.psum_valid_out, 0);
    sample(1'b0, 8'd6, 16'd0);
    checkOutput("t4_noValid5", bus.psum_valid_out, 0);
    sample(1'b0, 8'd7, 16'd0);
    checkOutput("t4_valid6", bus.psum_valid_out, 1);
    checkOutput("t4_psum6",  bus.psum_out, 28);
    idle();
    checkOutput("t4_psum7",  bus.psum_out, 34);

    // Stall with a valid result on the output; inputs during the stall are ignored.
    sample(1'b1, 8'd10, 16'd0);
    sample(1'b0, 8'd20, 16'd0);
    sample(1'b0, 8'd30, 16'd0);
    sample(1'b0, 8'd40, 16'd0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'd99, 16'd7, 1'b1, 12'h000);
    checkOutput("t5_stallValid", bus.psum_valid_out, 1);
    checkOutput("t5_stallPsum",  bus.psum_out, 100);
    checkOutput("t5_stallFilt",  bus.filt_out, 12'h321);
    checkOutput("t5_stallIfmap", bus.ifmap_out, 40);
    en = 1'b1;
    idle();
    checkOutput("t5_resume", bus.psum_out, 160);

    // Weight load coinciding with an accept.
    sample(1'b1, 8'd10, 16'd0);
    sample(1'b0, 8'd20, 16'd0);
    sample(1'b0, 8'd30, 16'd0);
    applyStimulus(1'b1, 1'b0, 8'd40, 16'd0, 1'b1, 12'h111);
    checkOutput("t6_psum30", bus.psum_out, 100);
    checkOutput("t6_newFilt", bus.filt_out, 12'h111);
    sample(1'b0, 8'd50, 16'd0);
    checkOutput("t6_oldW", bus.psum_out, 160);
    idle();
    checkOutput("t6_newW", bus.psum_out, 120);

    // Reset mid-stream.
    sample(1'b1, 8'd1, 16'd0);
    sample(1'b0, 8'd2, 16'd0);
    rst_n = 1'b0;
    sample(1'b0, 8'd3, 16'd0);
    checkOutput("t6_rstValid", bus.psum_valid_out, 0);
    checkOutput("t6_rstPsum",  bus.psum_out, 0);
    checkOutput("t6_rstSat",   bus.sat_flag, 0);
    checkOutput("t6_rstFilt",  bus.filt_out, 0);
    checkOutput("t6_rstIfmap", bus.ifmap_out, 0);
    rst_n = 1'b1;
    loadW(12'h321);
    sample(1'b0, 8'd7, 16'd0);
    sample(1'b0, 8'd8, 16'd0);
    checkOutput("t6_fillRestart7", bus.psum_valid_out, 0);
    sample(1'b0, 8'd9, 16'd0);
    checkOutput("t6_fillRestart8", bus.psum_valid_out, 0);
    idle();
    checkOutput("t6_firstAfterRst", bus.psum_out, 46);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
